// File: rtl/mem_resp.sv
// mem_resp: single-port 16-bit word RAM behind a fixed-latency request/response
// handshake. A request is latched in IDLE, held for WAIT_CYCLES wait states,
// and then performed on the RESP edge with a one-cycle done pulse.
// Optional macro MEM_RESP_DECODE_EN enables the instruction-field decode
// registers (opCode_out / br_nzp_out / offset_out) updated by successful reads;
// without it those outputs are tied to 0.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for req; done may still be high from last access
// S_WAIT | counting down wait states for the latched access
// S_RESP | next edge performs the access and raises done
module mem_resp #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [15:0] addr_in,
  input  logic        wea_in,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        done,
  output logic        busy,
  output logic        err,
  output logic [3:0]  opCode_out,
  output logic [8:0]  offset_out,
  output logic [2:0]  br_nzp_out
);

  localparam int          DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic        wea_q, wea_d;
  logic [15:0] din_q, din_d;
  logic [15:0] dout_q, dout_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic [15:0] mem [DEPTH];
  logic        mem_we;
  logic [DEPTH_LOG2-1:0] idx;
  logic        oor;

  assign idx = addr_q[DEPTH_LOG2-1:0];
  // Any address bit above the RAM depth makes the access out of range.
  assign oor = (addr_q >> DEPTH_LOG2) != 16'd0;

`ifdef MEM_RESP_DECODE_EN
  logic [3:0] opcode_q, opcode_d;
  logic [8:0] offset_q, offset_d;
  logic [2:0] nzp_q, nzp_d;
`endif

  // Next-state logic: sequencing, countdown and the access itself at RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wea_d   = wea_q;
    din_d   = din_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    err_d   = err_q;
    mem_we  = 1'b0;
`ifdef MEM_RESP_DECODE_EN
    opcode_d = opcode_q;
    offset_d = offset_q;
    nzp_d    = nzp_q;
`endif
    case (state_q)
      S_IDLE: begin
        // The edge on which done falls still belongs to the previous access.
        if (req && !done_q) begin
          addr_d  = addr_in;
          wea_d   = wea_in;
          din_d   = din;
          cnt_d   = WAIT_INIT;
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (oor) begin
          err_d  = 1'b1;
          dout_d = 16'd0;
        end else begin
          err_d = 1'b0;
          if (wea_q) begin
            mem_we = 1'b1;
          end else begin
            dout_d = mem[idx];
`ifdef MEM_RESP_DECODE_EN
            opcode_d = mem[idx][15:12];
            nzp_d    = mem[idx][11:9];
            offset_d = mem[idx][8:0];
`endif
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'd0;
      wea_q   <= 1'b0;
      din_q   <= 16'd0;
      dout_q  <= 16'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wea_q   <= wea_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // RAM write port; contents survive reset, but a reset edge blocks the write.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[idx] <= din_q;
    end
  end

`ifdef MEM_RESP_DECODE_EN
  // Decode fields of the last successful read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opcode_q <= 4'd0;
      offset_q <= 9'd0;
      nzp_q    <= 3'd0;
    end else begin
      opcode_q <= opcode_d;
      offset_q <= offset_d;
      nzp_q    <= nzp_d;
    end
  end

  assign opCode_out = opcode_q;
  assign offset_out = offset_q;
  assign br_nzp_out = nzp_q;
`else
  assign opCode_out = 4'd0;
  assign offset_out = 9'd0;
  assign br_nzp_out = 3'd0;
`endif

  assign dout = dout_q;
  assign done = done_q;
  assign busy = busy_q;
  assign err  = err_q;

endmodule
